// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch controller:
// bus widths, FSM state encoding and PC alignment helper.
package fetch_ctrl_pkg;

  localparam int REG_W  = 64;
  localparam int INST_W = 32;

  typedef logic [REG_W-1:0]  reg_bus_t;
  typedef logic [INST_W-1:0] inst_bus_t;

  localparam reg_bus_t ZERO_WORD = '0;

  typedef enum logic [1:0] {
    FC_IDLE = 2'd0,
    FC_REQ  = 2'd1,
    FC_WAIT = 2'd2,
    FC_HOLD = 2'd3
  } fc_state_e;

  // Instructions are word aligned; the low two address bits are never used.
  function automatic reg_bus_t align_pc(input reg_bus_t pc);
    return pc & ~reg_bus_t'(3);
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-side bundle: execute redirect, instruction-memory handshake and
// the decode-facing valid/ready instruction channel.
interface fetch_ctrl_if;
  import fetch_ctrl_pkg::*;

  logic      redirect_valid;
  reg_bus_t  redirect_pc;
  logic      imem_req;
  reg_bus_t  imem_addr;
  logic      imem_gnt;
  logic      imem_rvalid;
  inst_bus_t imem_rdata;
  logic      inst_valid;
  inst_bus_t inst;
  reg_bus_t  inst_pc;
  logic      inst_ready;

  modport master (
    input  redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
    output imem_req, imem_addr, inst_valid, inst, inst_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
    input  imem_req, imem_addr, inst_valid, inst, inst_pc
  );

endinterface

// File: rtl/fetch_ctrl_pc_gen.sv
// Program counter: reset load, sequential +4 step and aligned redirect,
// with redirect taking priority over the sequential step.
module fetch_ctrl_pc_gen
  import fetch_ctrl_pkg::*;
#(
  parameter reg_bus_t RESET_PC = ZERO_WORD
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     load,
  input  reg_bus_t target,
  input  logic     inc,
  output reg_bus_t pc
);

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values of its neighbours, matching real hardware.
  always_ff @(posedge clk) begin
    if (rst)       pc <= RESET_PC;
    else if (load) pc <= align_pc(target);
    else if (inc)  pc <= pc + reg_bus_t'(4);
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: one outstanding imem request, wrong-path
// squash on redirect, and a single-entry output buffer towards decode.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter reg_bus_t RESET_PC = ZERO_WORD
) (
  input  logic         clk,
  input  logic         rst,
  fetch_ctrl_if.master bus
);

  fc_state_e state, state_nxt;
  reg_bus_t  pc;
  reg_bus_t  req_pc;
  logic      drop, drop_nxt;
  inst_bus_t inst_q;
  reg_bus_t  inst_pc_q;
  logic      deliver;
  logic      pc_inc;
  logic      pc_load;
  logic      granted;

  assign granted = (state == FC_REQ) && bus.imem_gnt;
  assign pc_load = bus.redirect_valid && (state != FC_IDLE);

  fetch_ctrl_pc_gen #(.RESET_PC(RESET_PC)) u_pc_gen (
    .clk    (clk),
    .rst    (rst),
    .load   (pc_load),
    .target (bus.redirect_pc),
    .inc    (pc_inc),
    .pc     (pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FC_IDLE;
      drop      <= 1'b0;
      req_pc    <= '0;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      state <= state_nxt;
      drop  <= drop_nxt;
      if (granted) req_pc <= pc;
      if (deliver) begin
        inst_q    <= bus.imem_rdata;
        inst_pc_q <= req_pc;
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    drop_nxt  = drop;
    deliver   = 1'b0;
    pc_inc    = 1'b0;
    unique case (state)
      FC_IDLE: state_nxt = FC_REQ;
      FC_REQ: begin
        if (bus.imem_gnt) begin
          pc_inc    = 1'b1;
          drop_nxt  = bus.redirect_valid;
          state_nxt = FC_WAIT;
        end
      end
      FC_WAIT: begin
        if (bus.imem_rvalid) begin
          drop_nxt = 1'b0;
          if (!drop && !bus.redirect_valid) begin
            deliver   = 1'b1;
            state_nxt = FC_HOLD;
          end else begin
            state_nxt = FC_REQ;
          end
        end else if (bus.redirect_valid) begin
          drop_nxt = 1'b1;
        end
      end
      FC_HOLD: begin
        // A redirect squashes the held word even when decode is ready.
        if (bus.redirect_valid || bus.inst_ready) state_nxt = FC_REQ;
      end
      default: state_nxt = FC_IDLE;
    endcase
  end

  assign bus.imem_req   = (state == FC_REQ);
  assign bus.imem_addr  = pc;
  assign bus.inst_valid = (state == FC_HOLD);
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table, hand-written wrap/reset
// sequence on a second instance, and randomized traffic against a model.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  localparam reg_bus_t WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  fetch_ctrl_if bus_a ();
  fetch_ctrl_if bus_b ();

  fetch_ctrl #(.RESET_PC(ZERO_WORD)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
  fetch_ctrl #(.RESET_PC(WRAP_PC))   dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

  logic [161:0] obs_a, obs_b;
  assign obs_a = {bus_a.imem_req, bus_a.imem_addr, bus_a.inst_valid, bus_a.inst, bus_a.inst_pc};
  assign obs_b = {bus_b.imem_req, bus_b.imem_addr, bus_b.inst_valid, bus_b.inst, bus_b.inst_pc};

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [161:0] act, input logic [161:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got {req,addr,valid,inst,pc}=%h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [161:0] outs(input logic req, input reg_bus_t addr, input logic valid,
                                        input inst_bus_t inst, input reg_bus_t ipc);
    return {req, addr, valid, inst, ipc};
  endfunction

  typedef struct {
    logic      rst, rv;
    reg_bus_t  rpc;
    logic      gnt, rvalid;
    inst_bus_t rdata;
    logic      ready, chk;
    logic [161:0] exp;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic rst, input logic rv, input reg_bus_t rpc, input logic gnt,
                              input logic rvalid, input inst_bus_t rdata, input logic ready,
                              input logic chk, input logic [161:0] exp);
    vec_t v;
    v.rst = rst; v.rv = rv; v.rpc = rpc; v.gnt = gnt; v.rvalid = rvalid;
    v.rdata = rdata; v.ready = ready; v.chk = chk; v.exp = exp;
    return v;
  endfunction

  task automatic drive_a(input logic rst, input logic rv, input reg_bus_t rpc, input logic gnt,
                         input logic rvalid, input inst_bus_t rdata, input logic ready);
    rst_a = rst;
    bus_a.redirect_valid = rv;  bus_a.redirect_pc = rpc;
    bus_a.imem_gnt = gnt;       bus_a.imem_rvalid = rvalid;
    bus_a.imem_rdata = rdata;   bus_a.inst_ready = ready;
  endtask

  task automatic drive_b(input logic rst, input logic gnt, input logic rvalid,
                         input inst_bus_t rdata, input logic ready);
    rst_b = rst;
    bus_b.redirect_valid = 1'b0; bus_b.redirect_pc = '0;
    bus_b.imem_gnt = gnt;        bus_b.imem_rvalid = rvalid;
    bus_b.imem_rdata = rdata;    bus_b.inst_ready = ready;
  endtask

  // Transaction-level model: a booting flag, the next fetch address, at most
  // one fetch in flight (possibly doomed) and at most one word held for decode.
  bit        m_boot, m_fl, m_dead, m_held;
  reg_bus_t  m_pc, m_fl_pc, m_ipc;
  inst_bus_t m_inst;

  function automatic logic [161:0] model_obs();
    return outs(!m_boot && !m_fl && !m_held, m_pc, m_held, m_inst, m_ipc);
  endfunction

  task automatic model_step(input logic rst, input logic rv, input reg_bus_t rpc, input logic gnt,
                            input logic rvalid, input inst_bus_t rdata, input logic ready);
    reg_bus_t tgt;
    tgt = {rpc[63:2], 2'b00};
    if (rst) begin
      m_boot = 1; m_fl = 0; m_dead = 0; m_held = 0;
      m_pc = '0; m_fl_pc = '0; m_inst = '0; m_ipc = '0;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (m_held) begin
      if (rv) m_pc = tgt;
      if (rv || ready) m_held = 0;
    end else if (m_fl) begin
      if (rv) m_pc = tgt;
      if (rvalid) begin
        if (!m_dead && !rv) begin
          m_held = 1; m_inst = rdata; m_ipc = m_fl_pc;
        end
        m_fl = 0; m_dead = 0;
      end else if (rv) begin
        m_dead = 1;
      end
    end else begin
      if (gnt) begin
        m_fl = 1; m_fl_pc = m_pc; m_dead = rv;
        m_pc = rv ? tgt : m_pc + 64'd4;
      end else if (rv) begin
        m_pc = tgt;
      end
    end
  endtask

  initial begin
    drive_a(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    drive_b(1'b1, 1'b0, 1'b0, '0, 1'b0);

    // Directed table: free run, redirect+ready in HOLD, 5-cycle grant stall,
    // redirect during WAIT to 0x1003, and 4 cycles of decode backpressure.
    vq.push_back(mk(1, 0, 0, 1, 1, 0, 1, 0, '0));
    vq.push_back(mk(0, 0, 0, 1, 1, 0, 1, 1, outs(0, 64'h0, 0, 0, 0)));
    vq.push_back(mk(0, 0, 0, 1, 1, 0, 1, 1, outs(1, 64'h0, 0, 0, 0)));
    vq.push_back(mk(0, 0, 0, 1, 1, 32'h1111_0000, 1, 1, outs(0, 64'h4, 0, 0, 0)));
    vq.push_back(mk(0, 0, 0, 1, 1, 32'hAAAA_0000, 1, 1, outs(0, 64'h4, 1, 32'h1111_0000, 64'h0)));
    vq.push_back(mk(0, 0, 0, 1, 1, 0, 1, 1, outs(1, 64'h4, 0, 32'h1111_0000, 64'h0)));
    vq.push_back(mk(0, 0, 0, 1, 1, 32'h2222_0004, 1, 1, outs(0, 64'h8, 0, 32'h1111_0000, 64'h0)));
    vq.push_back(mk(0, 0, 0, 1, 1, 0, 1, 1, outs(0, 64'h8, 1, 32'h2222_0004, 64'h4)));
    vq.push_back(mk(0, 0, 0, 1, 1, 0, 1, 1, outs(1, 64'h8, 0, 32'h2222_0004, 64'h4)));
    vq.push_back(mk(0, 0, 0, 1, 1, 32'h3333_0008, 1, 1, outs(0, 64'hC, 0, 32'h2222_0004, 64'h4)));
    vq.push_back(mk(0, 1, 64'h2000, 1, 1, 0, 1, 1, outs(0, 64'hC, 1, 32'h3333_0008, 64'h8)));
    for (int i = 0; i < 5; i++)
      vq.push_back(mk(0, 0, 0, 0, 1, 0, 1, 1, outs(1, 64'h2000, 0, 32'h3333_0008, 64'h8)));
    vq.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1, outs(1, 64'h2000, 0, 32'h3333_0008, 64'h8)));
    vq.push_back(mk(0, 1, 64'h1003, 1, 0, 0, 1, 1, outs(0, 64'h2004, 0, 32'h3333_0008, 64'h8)));
    vq.push_back(mk(0, 0, 0, 1, 1, 32'hDEAD_BEEF, 1, 1, outs(0, 64'h1000, 0, 32'h3333_0008, 64'h8)));
    vq.push_back(mk(0, 0, 0, 1, 1, 0, 1, 1, outs(1, 64'h1000, 0, 32'h3333_0008, 64'h8)));
    vq.push_back(mk(0, 0, 0, 1, 1, 32'h4444_1000, 1, 1, outs(0, 64'h1004, 0, 32'h3333_0008, 64'h8)));
    for (int i = 0; i < 4; i++)
      vq.push_back(mk(0, 0, 0, 1, 1, 32'h5555_0000, 0, 1, outs(0, 64'h1004, 1, 32'h4444_1000, 64'h1000)));
    vq.push_back(mk(0, 0, 0, 1, 1, 0, 1, 1, outs(0, 64'h1004, 1, 32'h4444_1000, 64'h1000)));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, outs(1, 64'h1004, 0, 32'h4444_1000, 64'h1000)));

    foreach (vq[i]) begin
      @(negedge clk);
      drive_a(vq[i].rst, vq[i].rv, vq[i].rpc, vq[i].gnt, vq[i].rvalid, vq[i].rdata, vq[i].ready);
      if (vq[i].chk) check($sformatf("vec%0d", i), obs_a, vq[i].exp);
    end

    // Wrap from ...FFFC to 0, then reset during WAIT with a stale response.
    @(negedge clk); drive_b(1, 1, 0, 0, 1);
    @(negedge clk); drive_b(0, 1, 0, 0, 1);
    check("b_reset", obs_b, outs(0, WRAP_PC, 0, 0, 0));
    @(negedge clk);
    check("b_first_req", obs_b, outs(1, WRAP_PC, 0, 0, 0));
    @(negedge clk); drive_b(0, 1, 1, 32'h0000_0013, 1);
    check("b_wrap_pc", obs_b, outs(0, 64'h0, 0, 0, 0));
    @(negedge clk); drive_b(0, 1, 0, 0, 1);
    check("b_wrap_hold", obs_b, outs(0, 64'h0, 1, 32'h13, WRAP_PC));
    @(negedge clk);
    check("b_req_zero", obs_b, outs(1, 64'h0, 0, 32'h13, WRAP_PC));
    @(negedge clk); drive_b(1, 1, 0, 0, 1);
    check("b_wait", obs_b, outs(0, 64'h4, 0, 32'h13, WRAP_PC));
    @(negedge clk); drive_b(0, 0, 1, 32'h0000_0BAD, 1);
    check("b_rst_in_wait", obs_b, outs(0, WRAP_PC, 0, 0, 0));
    @(negedge clk);
    check("b_stale_ignored", obs_b, outs(1, WRAP_PC, 0, 0, 0));
    @(negedge clk);
    check("b_still_req", obs_b, outs(1, WRAP_PC, 0, 0, 0));

    // Randomized traffic on dut_a against the model.
    for (int i = 0; i < 3000; i++) begin
      logic rst, rv, gnt, rvalid, ready;
      reg_bus_t rpc;
      inst_bus_t rdata;
      @(negedge clk);
      rst    = (i == 0) || ($urandom_range(255) == 0);
      rv     = ($urandom_range(5) == 0);
      rpc    = ($urandom_range(3) == 0) ? {60'hFFF_FFFF_FFFF_FFFF, 4'($urandom)}
                                        : {$urandom, $urandom};
      gnt    = $urandom_range(1) == 1;
      rvalid = $urandom_range(1) == 1;
      rdata  = $urandom;
      ready  = $urandom_range(2) != 0;
      drive_a(rst, rv, rpc, gnt, rvalid, rdata, ready);
      if (i != 0) check($sformatf("rand%0d", i), obs_a, model_obs());
      model_step(rst, rv, rpc, gnt, rvalid, rdata, ready);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
